// File: rtl/rf_io_port.sv
// Register-file I/O peripheral: buffered input FIFO with an IDLE/WAIT delivery FSM, and a
// single-word output holding register. Define IO_OVF_STICKY_EN to add the sticky out_ovf flag.
module rf_io_port #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             ext_data,
  input  logic                         ext_valid,
  output logic                         ext_ready,
  input  logic                         in_req,
  output logic                         in_stall,
  output logic [WIDTH-1:0]             InD,
  output logic                         InE,
  output logic [$clog2(DEPTH+1)-1:0]   in_count,
  input  logic [WIDTH-1:0]             OutD,
  input  logic                         out_wr,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready
`ifdef IO_OVF_STICKY_EN
  ,
  output logic                         out_ovf
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] ind_q, ind_d;
  logic             ine_q, ine_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop, empty, req_ok;
`ifdef IO_OVF_STICKY_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    empty     = (count_q == '0);
    // Readiness depends only on registered occupancy, so a full FIFO refuses even during a pop.
    ext_ready = (count_q < CW'(DEPTH));
    push      = ext_valid & ext_ready;
    // A request landing in the InE cycle belongs to an instruction already served.
    req_ok    = in_req & ~ine_q;
    pop       = 1'b0;
    in_stall  = 1'b0;
    state_d   = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d  = S_WAIT;
            in_stall = 1'b1;
          end
        end
      end
      S_WAIT: begin
        in_stall = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    head_d = pop  ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ind_d = pop ? mem[head_q] : ind_q;
    ine_d = pop;

    out_data_d  = out_wr ? OutD : out_data_q;
    out_valid_d = out_wr ? 1'b1 : (out_valid_q & ~out_ready);
`ifdef IO_OVF_STICKY_EN
    ovf_d = ovf_q | (out_wr & out_valid_q & ~out_ready);
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= ext_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      ind_q       <= '0;
      ine_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef IO_OVF_STICKY_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      ind_q       <= ind_d;
      ine_q       <= ine_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef IO_OVF_STICKY_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_count  = count_q;
  assign InD       = ind_q;
  assign InE       = ine_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
`ifdef IO_OVF_STICKY_EN
  assign out_ovf   = ovf_q;
`endif

endmodule
